// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - UART transmit frame sequencer
// Purpose: serialises one byte per tx_valid/tx_ready handshake as a start
//   bit, DATA_BITS data bits (LSB first), an optional parity bit and
//   STOP_BITS stop bits. Owns the baud-tick and bit counters.
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   tx_valid  byte available on tx_data
//   tx_data   byte to send, sampled only at handshake
//   tx_ready  idle and able to accept a byte
//   tx        registered serial line, idle high
//   busy      frame in progress
//   done      one-cycle pulse in the first idle cycle after stop
//   bit_idx   index of the data bit on tx, 0 outside DATA
module uart_tx_frame_ctrl #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done,
   output logic [2:0]           bit_idx
);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_frame_ctrl: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx_frame_ctrl: DATA_BITS must be 5..8");
   end
   if (PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
      $error("uart_tx_frame_ctrl: PARITY_EN and PARITY_ODD must be 0 or 1");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_frame_ctrl: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [BW-1:0]        baud_q, baud_d;
   logic [2:0]           bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 tick;

   assign tick = (baud_q == BAUD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   // tx is registered, so tx_d is the line level for the state being
   // entered; every branch that changes state also picks that state's level.
   always_comb begin
      state_d = state_q;
      baud_d  = '0;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      par_d   = par_q;
      done_d  = 1'b0;
      tx_d    = 1'b1;

      if (state_q != S_IDLE) begin
         baud_d = tick ? '0 : baud_q + BW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (tx_valid) begin
               state_d = S_START;
               shift_d = tx_data;
               // Parity is fixed at latch time since the shift register
               // is consumed during DATA.
               par_d   = (^tx_data) ^ (PARITY_ODD != 0);
               tx_d    = 1'b0;
            end
         end
         S_START: begin
            tx_d = 1'b0;
            if (tick) begin
               state_d = S_DATA;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            tx_d = shift_q[0];
            if (tick) begin
               if (bit_q == BIT_LAST) begin
                  bit_d  = '0;
                  stop_d = 1'b0;
                  if (PARITY_EN != 0) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            tx_d = par_q;
            if (tick) begin
               state_d = S_STOP;
               stop_d  = 1'b0;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (tick) begin
               if ((STOP_BITS == 1) || stop_q) begin
                  state_d = S_IDLE;
                  stop_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign tx       = tx_q;
   assign done     = done_q;
   assign busy     = (state_q != S_IDLE);
   assign tx_ready = (state_q == S_IDLE);
   assign bit_idx  = bit_q;

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
- Frame sequencer for the UART transmit path. Accepts one byte per valid/ready handshake and drives the serial line bit-by-bit: start, data LSB first, optional parity, stop.
- Owns the baud-tick counter and the bit counter.
- Sits between the host-side byte source and the tx pin; the receiver side consumes the same frame format.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY_EN, 0, 1 = append a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- tx_valid  in  1  byte available on tx_data.
- tx_data  in  DATA_BITS  byte to send; sampled only at handshake.
- tx_ready  out  1  controller idle and able to accept a byte.
- tx  out  1  serial line, registered; idle-high.
- busy  out  1  frame in progress (state != IDLE).
- done  out  1  one-cycle pulse at frame completion.
- bit_idx  out  3  index of the data bit currently on tx; 0 outside DATA.

Behaviour:
- Reset (async, rst=1): state=IDLE, tx=1, tx_ready=1, busy=0, done=0, bit_idx=0.
  - Baud and bit counters clear to 0; shift register clears to 0.
  - Takes effect immediately, including mid-frame: the frame is abandoned with no done pulse.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake: accept on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register and state goes to START.
  - tx_ready=0 from the next cycle.
  - tx_data and tx_valid are ignored while busy.
- Baud counter: counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - A state advances when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
  - Each bit therefore holds tx for exactly CLKS_PER_BIT cycles.
- START: tx=0 for CLKS_PER_BIT cycles, beginning the cycle after acceptance. Then go to DATA.
- DATA: tx = latched bit[bit_idx], starting at bit_idx=0.
  - bit_idx increments at each bit boundary.
  - After bit DATA_BITS-1, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: tx = XOR of the latched data bits, inverted when PARITY_ODD=1. Lasts one bit time, then go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; a bit counter tracks the 2nd stop bit. Then go to IDLE.
- Completion:
  - On the first IDLE cycle after STOP, done=1 for exactly one cycle.
  - tx_ready=1 in that same cycle, so a byte presented then is accepted and its START begins the next cycle.
  - Minimum gap between frames is 1 idle cycle (tx=1).
- Frame length: (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
- busy=1 exactly when state != IDLE; tx_ready is the inverse of busy.
- No register values outside the legal parameter ranges; parameters are checked by an elaboration-time assertion.

Test Plan:
- Reset, then idle 20 cycles -> tx=1, tx_ready=1, busy=0, done=0 throughout.
- Defaults, tx_data=8'hA5, one handshake.
  - tx sequence, per 16-cycle bit: 0, 1,0,1,0,0,1,0,1, 1.
  - done pulses exactly once, 160 cycles after the first START cycle.
- PARITY_EN=1, PARITY_ODD=0, data 8'h07 -> parity bit=1. With PARITY_ODD=1 -> parity bit=0. Frame = 176 cycles.
- STOP_BITS=2, CLKS_PER_BIT=4, data 8'hFF -> tx high for 8 cycles after the last data bit; frame = 44 cycles.
- tx_valid held high with data 8'h11 then 8'h22 -> second byte accepted in the done cycle; START follows after exactly 1 idle cycle. Changing tx_data mid-frame has no effect on the frame on the line.
- rst asserted during DATA bit 3 -> tx=1, busy=0, tx_ready=1 immediately, no done pulse. A new frame after release transmits correctly.
